// File: rtl/v810_bus_target.sv
// V810 external bus responder: decodes CPU bus cycles, forwards them to a REQ/ACK port and
// terminates each cycle with READYn (and SZRQn when configured as a 16-bit target).
module v810_bus_target #(
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter logic [31:0] MASK     = 32'h8000_0000,
    parameter bit          BUS16    = 1'b0,
    parameter bit          IO_SPACE = 1'b0,
    parameter bit          ACK_CYC  = 1'b0,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic [31:0] A,
    input  logic [31:0] D_I,
    output logic [31:0] D_O,
    output logic        D_OE,
    input  logic [3:0]  BEn,
    input  logic [1:0]  ST,
    input  logic        DAn,
    input  logic        MRQn,
    input  logic        RW,
    input  logic        BCYSTn,
    output logic        READYn,
    output logic        SZRQn,
    output logic        M_REQ,
    output logic        M_WE,
    output logic [31:0] M_A,
    output logic [3:0]  M_BE,
    output logic [31:0] M_WD,
    input  logic        M_ACK,
    input  logic [31:0] M_RD,
    output logic        TO_ERR
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAddr, StWait, StTerm} state_e;

    state_e            state_q, state_d;
    logic              rw_q, rw_d;
    logic              ack_q, ack_d;
    logic              lane_q, lane_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [31:0]       m_a_q, m_a_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [31:0]       m_wd_q, m_wd_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              to_err_q, to_err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              is_ack;
    logic              is_hit;
    logic [15:0]       rd_half;

    // Acknowledge cycles carry no meaningful address, so they bypass the decoder.
    assign is_ack  = MRQn && ST[0];
    assign is_hit  = ((A & MASK) == BASE) && (IO_SPACE ? (MRQn && (ST == 2'b10)) : !MRQn);
    assign rd_half = lane_q ? M_RD[31:16] : M_RD[15:0];

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        ack_d    = ack_q;
        lane_d   = lane_q;
        m_req_d  = m_req_q;
        m_we_d   = m_we_q;
        m_a_d    = m_a_q;
        m_be_d   = m_be_q;
        m_wd_d   = m_wd_q;
        rdata_d  = rdata_q;
        to_err_d = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!BCYSTn) begin
                    if (is_ack) begin
                        if (ACK_CYC) begin
                            ack_d   = 1'b1;
                            rw_d    = RW;
                            state_d = StTerm;
                        end
                    end else if (is_hit) begin
                        ack_d   = 1'b0;
                        rw_d    = RW;
                        lane_d  = A[1];
                        m_we_d  = !RW;
                        m_a_d   = A;
                        if (BUS16) begin
                            m_be_d = A[1] ? {~BEn[3:2], 2'b00} : {2'b00, ~BEn[1:0]};
                        end else begin
                            m_be_d = ~BEn;
                        end
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (!DAn) begin
                    if (!rw_q) begin
                        m_wd_d = BUS16 ? {D_I[15:0], D_I[15:0]} : D_I;
                    end
                    m_req_d = 1'b1;
                    cnt_d   = CntW'(TIMEOUT);
                    state_d = StWait;
                end
            end
            StWait: begin
                // An acknowledge arriving on the expiry cycle still completes normally.
                if (M_ACK) begin
                    m_req_d = 1'b0;
                    rdata_d = BUS16 ? {rd_half, rd_half} : M_RD;
                    state_d = StTerm;
                end else if (cnt_q <= CntW'(1)) begin
                    m_req_d  = 1'b0;
                    rdata_d  = 32'hFFFF_FFFF;
                    to_err_d = 1'b1;
                    state_d  = StTerm;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StTerm: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q  <= StIdle;
            rw_q     <= 1'b0;
            ack_q    <= 1'b0;
            lane_q   <= 1'b0;
            m_req_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_a_q    <= 32'h0;
            m_be_q   <= 4'h0;
            m_wd_q   <= 32'h0;
            rdata_q  <= 32'h0;
            to_err_q <= 1'b0;
            cnt_q    <= '0;
        end else if (CE) begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            ack_q    <= ack_d;
            lane_q   <= lane_d;
            m_req_q  <= m_req_d;
            m_we_q   <= m_we_d;
            m_a_q    <= m_a_d;
            m_be_q   <= m_be_d;
            m_wd_q   <= m_wd_d;
            rdata_q  <= rdata_d;
            to_err_q <= to_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign READYn = (state_q != StTerm);
    assign SZRQn  = !(BUS16 && (state_q == StTerm));
    assign D_OE   = (state_q == StTerm) && rw_q && !ack_q;
    assign D_O    = rdata_q;
    assign M_REQ  = m_req_q;
    assign M_WE   = m_we_q;
    assign M_A    = m_a_q;
    assign M_BE   = m_be_q;
    assign M_WD   = m_wd_q;
    assign TO_ERR = to_err_q;

endmodule
